mem_arbiter: RTL

Byte-serial memory arbiter that shares the single 8-bit RAM/IO port among three requesters: instruction fetch, load buffer and ROB store commit. It serialises each multi-byte access into per-byte address cycles and assembles or splits little-endian words. It also absorbs the 1-cycle RAM read latency, stalls IO writes on UART back-pressure, and aborts speculative traffic on misbranch. It sits between fetcher/slb/rob and the top-level `mem_*` pins.

---
 rtl/mem_arbiter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing the 8-bit RAM/IO port among instruction fetch,
// load buffer and ROB store commit. Priority is store > load > ifetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              in_misbranch,
  input  logic              in_if_req,
  input  logic [ADDR_W-1:0] in_if_addr,
  output logic              out_if_done,
  input  logic              in_ld_req,
  input  logic [ADDR_W-1:0] in_ld_addr,
  input  logic [2:0]        in_ld_size,
  input  logic              in_ld_signed,
  output logic              out_ld_done,
  input  logic              in_st_req,
  input  logic [ADDR_W-1:0] in_st_addr,
  input  logic [2:0]        in_st_size,
  input  logic [31:0]       in_st_data,
  output logic              out_st_done,
  output logic [31:0]       out_data,
  output logic              out_busy
);

  typedef enum logic [1:0] {IDLE, READ, IO_WAIT, WRITE} state_t;
  typedef enum logic [1:0] {SRC_IF, SRC_LD, SRC_ST} src_t;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       buf_q, buf_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic              iss_v_q, iss_v_d;
  logic              cap_v_q, cap_v_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              ld_done_q, ld_done_d;
  logic              st_done_q, st_done_d;
  logic [31:0]       out_data_q, out_data_d;

  logic st_ok, ld_ok, if_ok, st_is_io, last_cap;

  function automatic logic [2:0] size_len(input logic [2:0] sz);
    if (sz == 3'd1) return 3'd1;
    if (sz == 3'd2) return 3'd2;
    return 3'd4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] len,
                                         input logic sgn);
    if (len == 3'd1) return {{24{sgn & w[7]}}, w[7:0]};
    if (len == 3'd2) return {{16{sgn & w[15]}}, w[15:0]};
    return w;
  endfunction

  assign st_ok    = in_st_req && !st_done_q;
  assign ld_ok    = in_ld_req && !ld_done_q && !in_misbranch;
  assign if_ok    = in_if_req && !if_done_q && !in_misbranch;
  assign st_is_io = (in_st_addr[17:16] == 2'b11);
  assign last_cap = cap_v_q && (cap_idx_q == 3'(len_q - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (st_ok)               state_d = st_is_io ? IO_WAIT : WRITE;
          else if (ld_ok || if_ok) state_d = READ;
        end
        READ:    if (in_misbranch || last_cap) state_d = IDLE;
        IO_WAIT: if (!io_buffer_full)          state_d = WRITE;
        WRITE:   if (iss_q == len_q)           state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    src_d      = src_q;
    addr_d     = addr_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    buf_d      = buf_q;
    iss_d      = iss_q;
    cap_idx_d  = cap_idx_q;
    iss_v_d    = iss_v_q;
    cap_v_d    = cap_v_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = if_done_q;
    ld_done_d  = ld_done_q;
    st_done_d  = st_done_q;
    out_data_d = out_data_q;
    if (!rdy) begin
      // The byte in flight is lost while stalled; point the port at the first
      // uncaptured byte so the resume cycle itself is its re-issue.
      if (state_q == READ) begin
        mem_a_d = addr_q + ADDR_W'(cap_idx_q);
        iss_d   = 3'(cap_idx_q + 3'd1);
        iss_v_d = 1'b1;
        cap_v_d = 1'b0;
      end
    end else begin
      mem_a_d    = '0;
      mem_dout_d = '0;
      mem_wr_d   = 1'b0;
      if_done_d  = 1'b0;
      ld_done_d  = 1'b0;
      st_done_d  = 1'b0;
      out_data_d = '0;
      iss_v_d    = 1'b0;
      cap_v_d    = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (st_ok) begin
            src_d  = SRC_ST;
            addr_d = in_st_addr;
            len_d  = size_len(in_st_size);
            sgn_d  = 1'b0;
            buf_d  = in_st_data;
            iss_d  = '0;
            if (!st_is_io) begin
              mem_a_d    = in_st_addr;
              mem_dout_d = in_st_data[7:0];
              mem_wr_d   = 1'b1;
              iss_d      = 3'd1;
              st_done_d  = (size_len(in_st_size) == 3'd1);
            end
          end else if (ld_ok || if_ok) begin
            src_d     = ld_ok ? SRC_LD : SRC_IF;
            addr_d    = ld_ok ? in_ld_addr : in_if_addr;
            len_d     = ld_ok ? size_len(in_ld_size) : 3'd4;
            sgn_d     = ld_ok && in_ld_signed;
            buf_d     = '0;
            mem_a_d   = ld_ok ? in_ld_addr : in_if_addr;
            iss_d     = 3'd1;
            iss_v_d   = 1'b1;
            cap_idx_d = '0;
          end
        end
        READ: begin
          if (!in_misbranch) begin
            cap_v_d = iss_v_q;
            if (iss_q < len_q) begin
              mem_a_d = addr_q + ADDR_W'(iss_q);
              iss_d   = 3'(iss_q + 3'd1);
              iss_v_d = 1'b1;
            end
            if (cap_v_q) begin
              buf_d[{cap_idx_q[1:0], 3'b000} +: 8] = mem_din;
              cap_idx_d = 3'(cap_idx_q + 3'd1);
              if (last_cap) begin
                out_data_d = extend(buf_d, len_q, sgn_q);
                if_done_d  = (src_q == SRC_IF);
                ld_done_d  = (src_q == SRC_LD);
                mem_a_d    = '0;
                iss_v_d    = 1'b0;
                cap_v_d    = 1'b0;
              end
            end
          end
        end
        IO_WAIT: begin
          if (!io_buffer_full) begin
            mem_a_d    = addr_q;
            mem_dout_d = buf_q[7:0];
            mem_wr_d   = 1'b1;
            iss_d      = 3'd1;
            st_done_d  = (len_q == 3'd1);
          end
        end
        WRITE: begin
          if (iss_q < len_q) begin
            mem_a_d    = addr_q + ADDR_W'(iss_q);
            mem_dout_d = buf_q[{iss_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            iss_d      = 3'(iss_q + 3'd1);
            st_done_d  = (3'(iss_q + 3'd1) == len_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= SRC_IF;
      addr_q     <= '0;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      buf_q      <= '0;
      iss_q      <= '0;
      cap_idx_q  <= '0;
      iss_v_q    <= 1'b0;
      cap_v_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      src_q      <= src_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      buf_q      <= buf_d;
      iss_q      <= iss_d;
      cap_idx_q  <= cap_idx_d;
      iss_v_q    <= iss_v_d;
      cap_v_q    <= cap_v_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    mem_a       = mem_a_q;
    mem_dout    = mem_dout_q;
    mem_wr      = mem_wr_q & rdy;
    out_if_done = if_done_q;
    out_ld_done = ld_done_q;
    out_st_done = st_done_q;
    out_data    = out_data_q;
    out_busy    = (state_q != IDLE);
  end

endmodule
